// File: rtl/sparc_exu_thrreg_ckpt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sparc_exu_thrreg_ckpt_pkg : shared EXU defines for the per-thread  |
// | checkpointed register.                          Revision: 1.0      |
// +--------------------------------------------------------------------+
package sparc_exu_thrreg_ckpt_pkg;

    localparam int          EXU_NTHR_MAX = 8;
    localparam logic [63:0] EXU_RST_VAL  = 64'h0;

    // Register-side action a slice takes on one edge; checkpoint capture is orthogonal.
    typedef enum logic [1:0] {
        OP_HOLD    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_RESTORE = 2'd2,
        OP_ILLEGAL = 2'd3
    } slice_op_e;

endpackage : sparc_exu_thrreg_ckpt_pkg
`default_nettype wire

// File: rtl/sparc_exu_thrreg_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sparc_exu_thrreg_slice : one thread's register, checkpoint, valid  |
// | flag, masked write merge and restore priority.  Revision: 1.0      |
// +--------------------------------------------------------------------+
module sparc_exu_thrreg_slice
    import sparc_exu_thrreg_ckpt_pkg::*;
#(
    parameter int              SIZE    = 8,
    parameter logic [SIZE-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic            se,
    input  logic            sel,
    input  logic            wen,
    input  logic [SIZE-1:0] data_in,
    input  logic [SIZE-1:0] wmask,
    input  logic            ckpt,
    input  logic            restore,
    output logic [SIZE-1:0] reg_q,
    output logic [SIZE-1:0] wr_val,
    output logic            ckpt_vld,
    output logic            restore_ill
);

    logic [SIZE-1:0] ckpt_q;
    slice_op_e       op;
    logic            unused_se;

    assign unused_se = se;
    assign wr_val    = (reg_q & ~wmask) | (data_in & wmask);

    // A restore request, legal or not, always blocks the write on this thread.
    always_comb begin
        op = OP_HOLD;
        if (sel) begin
            if (restore) begin
                op = ckpt_vld ? OP_RESTORE : OP_ILLEGAL;
            end else if (wen) begin
                op = OP_WRITE;
            end
        end
    end

    assign restore_ill = (op == OP_ILLEGAL);

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            reg_q    <= RST_VAL;
            ckpt_q   <= RST_VAL;
            ckpt_vld <= 1'b0;
        end else begin
            case (op)
                OP_WRITE: begin
                    reg_q <= wr_val;
                end
                OP_RESTORE: begin
                    reg_q    <= ckpt_q;
                    ckpt_vld <= 1'b0;
                end
                default: begin
                end
            endcase
            // Checkpoint captures the pre-write value; restore takes priority over it.
            if (sel && ckpt && !restore) begin
                ckpt_q   <= reg_q;
                ckpt_vld <= 1'b1;
            end
        end
    end

endmodule : sparc_exu_thrreg_slice
`default_nettype wire

// File: rtl/sparc_exu_thrreg_ckpt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sparc_exu_thrreg_ckpt : NTHR-way per-thread register with masked   |
// | writes, read bypass and checkpoint/restore.     Revision: 1.0      |
// +--------------------------------------------------------------------+
module sparc_exu_thrreg_ckpt
    import sparc_exu_thrreg_ckpt_pkg::*;
#(
    parameter int              SIZE    = 8,
    parameter int              NTHR    = 4,
    parameter logic [SIZE-1:0] RST_VAL = EXU_RST_VAL[SIZE-1:0],
    parameter int              BYPASS  = 1
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic            se,
    input  logic [NTHR-1:0] thr_out,
    input  logic            wen_w,
    input  logic [NTHR-1:0] thr_w,
    input  logic [SIZE-1:0] data_in_w,
    input  logic [SIZE-1:0] wmask_w,
    input  logic            ckpt_w,
    input  logic            restore_w,
    output logic [SIZE-1:0] data_out,
    output logic [NTHR-1:0] ckpt_vld,
    output logic            restore_err
);

    logic [SIZE-1:0] reg_q  [NTHR];
    logic [SIZE-1:0] wr_val [NTHR];
    logic [NTHR-1:0] ill;
    logic            bypass_hit;

    generate
        for (genvar t = 0; t < NTHR; t++) begin : g_slice
            sparc_exu_thrreg_slice #(
                .SIZE    (SIZE),
                .RST_VAL (RST_VAL)
            ) u_slice (
                .clk         (clk),
                .arst_l      (arst_l),
                .se          (se),
                .sel         (thr_w[t]),
                .wen         (wen_w),
                .data_in     (data_in_w),
                .wmask       (wmask_w),
                .ckpt        (ckpt_w),
                .restore     (restore_w),
                .reg_q       (reg_q[t]),
                .wr_val      (wr_val[t]),
                .ckpt_vld    (ckpt_vld[t]),
                .restore_ill (ill[t])
            );
        end
    endgenerate

    // Bypass only when the write targets exactly the thread set being read.
    assign bypass_hit = (BYPASS != 0) && wen_w && !restore_w && (thr_w == thr_out);

    always_comb begin
        data_out = '0;
        for (int t = 0; t < NTHR; t++) begin
            if (thr_out[t]) begin
                data_out = data_out | (bypass_hit ? wr_val[t] : reg_q[t]);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            restore_err <= 1'b0;
        end else begin
            restore_err <= |ill;
        end
    end

endmodule : sparc_exu_thrreg_ckpt
`default_nettype wire

// File: tb/tb_sparc_exu_thrreg_ckpt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sparc_exu_thrreg_ckpt : scoreboard bench, two DUT builds        |
// | (bypass/0x5A reset and no-bypass/zero reset).   Revision: 1.0      |
// +--------------------------------------------------------------------+
module tb_sparc_exu_thrreg_ckpt;

    logic       clk = 1'b0;
    logic       arst_l = 1'b0;
    logic       se = 1'b0;
    logic [3:0] thr_out = '0;
    logic [3:0] thr_w = '0;
    logic       wen_w = 1'b0;
    logic       ckpt_w = 1'b0;
    logic       restore_w = 1'b0;
    logic [7:0] data_in_w = '0;
    logic [7:0] wmask_w = '0;
    logic [7:0] dout_a, dout_b;
    logic [3:0] vld_a, vld_b;
    logic       err_a, err_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sparc_exu_thrreg_ckpt #(.SIZE(8), .NTHR(4), .RST_VAL(8'h5A), .BYPASS(1)) dut_a (
        .clk(clk), .arst_l(arst_l), .se(se), .thr_out(thr_out), .wen_w(wen_w),
        .thr_w(thr_w), .data_in_w(data_in_w), .wmask_w(wmask_w), .ckpt_w(ckpt_w),
        .restore_w(restore_w), .data_out(dout_a), .ckpt_vld(vld_a), .restore_err(err_a));

    sparc_exu_thrreg_ckpt #(.SIZE(8), .NTHR(4), .RST_VAL(8'h00), .BYPASS(0)) dut_b (
        .clk(clk), .arst_l(arst_l), .se(se), .thr_out(thr_out), .wen_w(wen_w),
        .thr_w(thr_w), .data_in_w(data_in_w), .wmask_w(wmask_w), .ckpt_w(ckpt_w),
        .restore_w(restore_w), .data_out(dout_b), .ckpt_vld(vld_b), .restore_err(err_b));

    typedef struct {
        logic [7:0] da;
        logic [7:0] db;
        logic [3:0] va;
        logic [3:0] vb;
        logic       ea;
        logic       eb;
    } exp_t;

    exp_t sbq[$];

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    bit [7:0] m_reg [2][4];
    bit [7:0] m_ck  [2][4];
    bit [3:0] m_vld [2];
    bit       m_err [2];
    bit [7:0] m_rv  [2] = '{8'h5A, 8'h00};
    bit       m_byp [2] = '{1'b1, 1'b0};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 4; t++) begin
                m_reg[i][t] = m_rv[i];
                m_ck[i][t]  = m_rv[i];
            end
            m_vld[i] = '0;
            m_err[i] = 1'b0;
        end
    endtask

    function automatic bit [7:0] model_read(input int i, input bit [3:0] to, input bit [3:0] tw,
                                            input bit we, input bit [7:0] d, input bit [7:0] m,
                                            input bit rs);
        bit [7:0] r = 0;
        bit       byp = m_byp[i] && we && !rs && (tw == to);
        for (int t = 0; t < 4; t++) begin
            if (to[t]) begin
                if (byp) r |= (m_reg[i][t] & ~m) | (d & m);
                else     r |= m_reg[i][t];
            end
        end
        return r;
    endfunction

    task automatic push_expect(input bit [3:0] to, input bit [3:0] tw, input bit we,
                               input bit [7:0] d, input bit [7:0] m, input bit rs);
        exp_t e;
        e.da = model_read(0, to, tw, we, d, m, rs);
        e.db = model_read(1, to, tw, we, d, m, rs);
        e.va = m_vld[0];
        e.vb = m_vld[1];
        e.ea = m_err[0];
        e.eb = m_err[1];
        sbq.push_back(e);
    endtask

    task automatic model_step(input bit [3:0] tw, input bit we, input bit [7:0] d,
                              input bit [7:0] m, input bit ck, input bit rs);
        for (int i = 0; i < 2; i++) begin
            bit errn = 0;
            for (int t = 0; t < 4; t++) begin
                if (tw[t]) begin
                    if (rs) begin
                        if (m_vld[i][t]) begin
                            m_reg[i][t] = m_ck[i][t];
                            m_vld[i][t] = 1'b0;
                        end else begin
                            errn = 1;
                        end
                    end else begin
                        bit [7:0] old = m_reg[i][t];
                        if (we) m_reg[i][t] = (old & ~m) | (d & m);
                        if (ck) begin
                            m_ck[i][t]  = old;
                            m_vld[i][t] = 1'b1;
                        end
                    end
                end
            end
            m_err[i] = errn;
        end
    endtask

    task automatic cyc(input bit [3:0] to, input bit [3:0] tw, input bit we, input bit [7:0] d,
                       input bit [7:0] m, input bit ck, input bit rs);
        @(negedge clk);
        arst_l = 1'b1;
        thr_out = to; thr_w = tw; wen_w = we; data_in_w = d; wmask_w = m;
        ckpt_w = ck; restore_w = rs;
        push_expect(to, tw, we, d, m, rs);
        model_step(tw, we, d, m, ck, rs);
    endtask

    task automatic rst_cyc(input bit [3:0] to);
        @(negedge clk);
        arst_l = 1'b0;
        thr_out = to; thr_w = '0; wen_w = 0; data_in_w = '0; wmask_w = '0;
        ckpt_w = 0; restore_w = 0;
        model_reset();
        push_expect(to, 4'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    endtask

    // Monitor: samples 2ns after the stimulus edge, well away from posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("data_out_a", dout_a, e.da);
                chk("data_out_b", dout_b, e.db);
                chk("ckpt_vld_a", {4'b0, vld_a}, {4'b0, e.va});
                chk("ckpt_vld_b", {4'b0, vld_b}, {4'b0, e.vb});
                chk("restore_err_a", {7'b0, err_a}, {7'b0, e.ea});
                chk("restore_err_b", {7'b0, err_b}, {7'b0, e.eb});
            end
        end
    end

    initial begin
        bit [3:0] to, tw;
        rst_cyc(4'b0001);
        rst_cyc(4'b1111);
        cyc(4'b0001, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        cyc(4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        // Masked write on thread 1, bypass visible on dut_a only
        cyc(4'b0010, 4'b0010, 1, 8'hA0, 8'hFF, 0, 0);
        cyc(4'b0010, 4'b0010, 1, 8'hFF, 8'h0F, 0, 0);
        cyc(4'b0010, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        cyc(4'b1101, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        cyc(4'b0100, 4'b0100, 1, 8'h33, 8'hFF, 0, 0);
        cyc(4'b0100, 4'b0100, 1, 8'hC3, 8'h00, 0, 0);
        // Checkpoint round trip on thread 3
        cyc(4'b1000, 4'b1000, 1, 8'h11, 8'hFF, 0, 0);
        cyc(4'b1000, 4'b1000, 0, 8'h00, 8'h00, 1, 0);
        cyc(4'b1000, 4'b1000, 1, 8'h22, 8'hFF, 0, 0);
        cyc(4'b1000, 4'b1000, 0, 8'h00, 8'h00, 0, 1);
        cyc(4'b1000, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        cyc(4'b1000, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        // Illegal restore on thread 0
        cyc(4'b0001, 4'b0001, 0, 8'h00, 8'h00, 0, 1);
        cyc(4'b0001, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        cyc(4'b0001, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        // Restore + write + ckpt together on thread 2
        cyc(4'b0100, 4'b0100, 1, 8'h44, 8'hFF, 0, 0);
        cyc(4'b0100, 4'b0100, 1, 8'h55, 8'hFF, 1, 0);
        cyc(4'b0100, 4'b0100, 1, 8'h66, 8'hFF, 1, 1);
        cyc(4'b0100, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        cyc(4'b0100, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        // Pending error pulse cancelled by reset
        cyc(4'b1111, 4'b0011, 0, 8'h00, 8'h00, 0, 1);
        rst_cyc(4'b1111);
        cyc(4'b1111, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst_cyc(4'($urandom));
            end else begin
                case ($urandom_range(0, 5))
                    0:       tw = 4'($urandom);
                    1:       tw = 4'b0000;
                    default: tw = 4'(1 << $urandom_range(0, 3));
                endcase
                to = ($urandom_range(0, 2) == 0) ? tw : 4'($urandom);
                cyc(to, tw, 1'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            end
        end
        cyc(4'b1111, 4'b0000, 0, 8'h00, 8'h00, 0, 0);
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sparc_exu_thrreg_ckpt
`default_nettype wire
